// File: rtl/vcache_stat_snapshot.sv
// vcache_stat_snapshot
//   Stat-collection stage downstream of a vcache verify stage. Counts accepted
//   load/store/miss responses. On a print request it freezes a tagged snapshot
//   of all counters and streams it out one word per beat.
//
//   Build option: VCACHE_STAT_SATURATE_EN
//     defined   -> live counters saturate at all-ones
//     undefined -> live counters wrap modulo 2^ctr_width_p
//   drop_count_o saturates in both builds.
//
// Ports
//   clk_i, reset_i    clock, synchronous active-high reset
//   inc_ld_i          accepted load response
//   inc_st_i          accepted store response
//   inc_ld_miss_i     accepted load response was a miss
//   inc_st_miss_i     accepted store response was a miss
//   global_ctr_i      free-running global cycle counter (32 bits)
//   print_stat_v_i    snapshot request pulse
//   print_stat_tag_i  tag attached to the request
//   v_o/data_o/idx_o  snapshot word stream (idx 0..5)
//   yumi_i            consumer takes the current word
//   busy_o            snapshot in flight
//   drop_count_o      requests dropped while busy (saturating)
//
// Handshake: a word transfers on a cycle where v_o=1 and yumi_i=1. While
// v_o=1 and yumi_i=0, data_o and idx_o hold. yumi_i with v_o=0 is ignored.
// Word order: 0 tag, 1 global_ctr, 2 ld, 3 st, 4 ld_miss, 5 st_miss.

module vcache_stat_snapshot #(
  parameter int ctr_width_p = 32,
  parameter int tag_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   inc_ld_i,
  input  logic                   inc_st_i,
  input  logic                   inc_ld_miss_i,
  input  logic                   inc_st_miss_i,
  input  logic [31:0]            global_ctr_i,
  input  logic                   print_stat_v_i,
  input  logic [tag_width_p-1:0] print_stat_tag_i,
  output logic                   v_o,
  output logic [ctr_width_p-1:0] data_o,
  output logic [2:0]             idx_o,
  input  logic                   yumi_i,
  output logic                   busy_o,
  output logic [7:0]             drop_count_o
);

  typedef logic [ctr_width_p-1:0] ctr_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam ctr_t one_lp = ctr_t'(1);

  // Counter step; the build option selects wrap or saturate at all-ones.
  function automatic ctr_t bump(input ctr_t c, input logic en);
    bump = c;
    if (en) begin
`ifdef VCACHE_STAT_SATURATE_EN
      if (c != '1) bump = c + one_lp;
`else
      bump = c + one_lp;
`endif
    end
  endfunction

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       capture;
  logic       drop;

  ctr_t ld_q, st_q, ld_miss_q, st_miss_q;
  ctr_t ld_d, st_d, ld_miss_d, st_miss_d;

  ctr_t snap_tag_q, snap_gctr_q, snap_ld_q, snap_st_q, snap_ld_miss_q, snap_st_miss_q;

  logic [7:0] drop_q, drop_d;

  // Live counters advance regardless of snapshot activity.
  assign ld_d      = bump(ld_q,      inc_ld_i);
  assign st_d      = bump(st_q,      inc_st_i);
  assign ld_miss_d = bump(ld_miss_q, inc_ld_miss_i);
  assign st_miss_d = bump(st_miss_q, inc_st_miss_i);

  // Any request seen outside IDLE is dropped, including the final-yumi cycle.
  assign drop   = print_stat_v_i && (state_q == SEND);
  assign drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (print_stat_v_i) begin
          capture = 1'b1;
          state_d = SEND;
          idx_d   = 3'd0;
        end
      end
      SEND: begin
        if (yumi_i) begin
          if (idx_q == 3'd5) begin
            state_d = IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      idx_q          <= 3'd0;
      ld_q           <= '0;
      st_q           <= '0;
      ld_miss_q      <= '0;
      st_miss_q      <= '0;
      snap_tag_q     <= '0;
      snap_gctr_q    <= '0;
      snap_ld_q      <= '0;
      snap_st_q      <= '0;
      snap_ld_miss_q <= '0;
      snap_st_miss_q <= '0;
      drop_q         <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ld_q      <= ld_d;
      st_q      <= st_d;
      ld_miss_q <= ld_miss_d;
      st_miss_q <= st_miss_d;
      drop_q    <= drop_d;
      if (capture) begin
        // Pre-increment values: same-cycle pulses only reach the live counters.
        snap_tag_q     <= ctr_t'(print_stat_tag_i);
        snap_gctr_q    <= ctr_t'(global_ctr_i);
        snap_ld_q      <= ld_q;
        snap_st_q      <= st_q;
        snap_ld_miss_q <= ld_miss_q;
        snap_st_miss_q <= st_miss_q;
      end
    end
  end

  always_comb begin
    data_o = '0;
    if (state_q == SEND) begin
      unique case (idx_q)
        3'd0:    data_o = snap_tag_q;
        3'd1:    data_o = snap_gctr_q;
        3'd2:    data_o = snap_ld_q;
        3'd3:    data_o = snap_st_q;
        3'd4:    data_o = snap_ld_miss_q;
        3'd5:    data_o = snap_st_miss_q;
        default: data_o = '0;
      endcase
    end
  end

  assign v_o          = (state_q == SEND);
  assign busy_o       = (state_q == SEND);
  assign idx_o        = idx_q;
  assign drop_count_o = drop_q;

endmodule
